// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_pkg : constants and types shared by the fetch stage    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package instruction_fetch_pkg;

  localparam int unsigned c_INSTR_BYTES = 4;
  localparam logic [31:0] c_NOP         = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_buffer : circular FIFO with synchronous flush and occupancy count  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_buffer #(
  parameter  int DEPTH   = 2,
  parameter  int DATA_W  = 64,
  localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [c_CNT_W-1:0] o_count
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd;
  logic [c_PTR_W-1:0] r_wr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == c_LAST) ? '0 : r_wr + c_PTR_W'(1);
      if (w_do_pop)  r_rd <= (r_rd == c_LAST) ? '0 : r_rd + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch : single-outstanding fetch unit with buffered output   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               Width   = 32,
  parameter logic [Width-1:0] ResetPc = '0,
  parameter int               Depth   = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [Width-1:0] imem_addr,
  output logic             imem_valid,
  input  logic [Width-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  input  logic             halt,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [Width-1:0] if_pc,
  output logic [Width-1:0] if_instr
);

  localparam int               c_ENTRY_W = 2 * Width;
  localparam int               c_CNT_W   = $clog2(Depth + 1);
  localparam logic [Width-1:0] c_ALIGN   = ~Width'(c_INSTR_BYTES - 1);
  localparam logic [Width-1:0] c_STEP    = Width'(c_INSTR_BYTES);

  logic [Width-1:0]     r_pc;
  logic [Width-1:0]     r_req_pc;
  logic                 r_inflight;
  fetch_state_e         r_state;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CNT_W-1:0]   w_count;
  logic [c_CNT_W:0]     w_occ;
  logic [c_CNT_W:0]     w_lim;
  logic [c_ENTRY_W-1:0] w_head;

  assign w_pop  = if_valid & if_ready;
  // Buffered plus in-flight entries must fit once this cycle's pop is taken.
  assign w_occ  = (c_CNT_W + 1)'(w_count) + (c_CNT_W + 1)'(r_inflight);
  assign w_lim  = (c_CNT_W + 1)'(Depth) + (c_CNT_W + 1)'(w_pop);
  assign w_issue = ~rst & ~halt & ~redirect_valid & (w_occ < w_lim)
                 & ~(w_full & ~w_pop);
  // A response returning in a redirect cycle belongs to the old path.
  assign w_push = r_inflight & ~redirect_valid & ~rst;

  assign imem_valid = w_issue;
  assign imem_addr  = r_pc;
  assign if_valid   = ~w_empty;
  assign {if_pc, if_instr} = w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= ResetPc & c_ALIGN;
      r_inflight <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) r_pc <= redirect_pc & c_ALIGN;
      else if (w_issue)   r_pc <= r_pc + c_STEP;
      if (w_issue)        r_req_pc <= r_pc;
      case (r_state)
        ST_RUN:    if (halt)  r_state <= ST_HALTED;
        ST_HALTED: if (!halt) r_state <= ST_RUN;
        default:              r_state <= ST_RUN;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH  (Depth),
    .DATA_W (c_ENTRY_W)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_req_pc, imem_data}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch : directed and random checks against a stream model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam int          W   = 32;
  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  instruction_fetch #(.Width(W), .ResetPc(RPC), .Depth(D)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Stream model: entries owed to decode, next address to fetch, next pc to deliver
  int          occ_m = 0;
  bit          infl_m = 1'b0;
  logic [31:0] fetch_pc = RPC;
  logic [31:0] exp_pc = RPC;

  bit          prev_hold = 1'b0;
  logic [31:0] hold_pc, hold_instr;
  logic        s_if_valid, s_imem_valid;
  logic [31:0] s_if_pc, s_if_instr, s_imem_addr;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          pop, exp_issue, iss;
    logic [31:0] a;
    @(negedge clk);
    s_if_valid   = if_valid;
    s_if_pc      = if_pc;
    s_if_instr   = if_instr;
    s_imem_valid = imem_valid;
    s_imem_addr  = imem_addr;
    pop = (if_valid === 1'b1) && (if_ready === 1'b1);
    chk1("if_valid", if_valid, (occ_m - int'(infl_m)) > 0);
    exp_issue = !rst && !halt && !redirect_valid && ((occ_m - int'(pop)) < D);
    chk1("issue", imem_valid, exp_issue);
    if (imem_valid === 1'b1) chk("fetch_addr", imem_addr, fetch_pc);
    if (pop) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, mem[exp_pc[9:2]]);
    end
    if (prev_hold) begin
      chk("hold_pc", if_pc, hold_pc);
      chk("hold_instr", if_instr, hold_instr);
    end
    prev_hold  = (if_valid === 1'b1) && !if_ready && !redirect_valid && !rst;
    hold_pc    = if_pc;
    hold_instr = if_instr;
    iss = (imem_valid === 1'b1);
    a   = imem_addr;
    occ_m  = occ_m - int'(pop) + int'(exp_issue);
    infl_m = exp_issue;
    if (exp_issue) fetch_pc = fetch_pc + 32'd4;
    if (pop)       exp_pc   = exp_pc + 32'd4;
    if (redirect_valid) begin
      occ_m = 0; infl_m = 1'b0;
      fetch_pc = redirect_pc & ~32'd3;
      exp_pc   = redirect_pc & ~32'd3;
    end
    if (rst) begin
      occ_m = 0; infl_m = 1'b0;
      fetch_pc = RPC;
      exp_pc   = RPC;
    end
    @(posedge clk);
    #1;
    if (iss) imem_data = mem[a[9:2]];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    if_ready = 1'b1; imem_data = '0;
    repeat (3) step();

    // Reset release: first issue at ResetPc, first word two cycles later
    rst = 1'b0;
    step();
    chk1("rel_issue", s_imem_valid, 1'b1);
    chk("rel_addr", s_imem_addr, RPC);
    step(); step();
    chk1("rel_c2_valid", s_if_valid, 1'b1);
    chk("rel_c2_pc", s_if_pc, 32'h0);
    chk("rel_c2_instr", s_if_instr, 32'h0000_0013);
    step();
    chk("rel_c3_pc", s_if_pc, 32'h4);
    chk("rel_c3_instr", s_if_instr, 32'h0010_0093);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("throughput", s_if_valid & s_imem_valid, 1'b1);
    end

    // Backpressure fills the buffer, then drains without loss
    if_ready = 1'b0;
    repeat (5) step();
    chk1("bp_no_issue", s_imem_valid, 1'b0);
    chk1("bp_valid", s_if_valid, 1'b1);
    if_ready = 1'b1;
    repeat (6) step();

    // Redirect the cycle after the fetch of 0x10
    rst = 1'b1; step(); rst = 1'b0;
    repeat (5) step();
    chk("pre_redir_addr", s_imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    chk1("redir_flush", s_if_valid, 1'b0);
    chk("redir_addr", s_imem_addr, 32'h40);
    step();
    chk1("redir_gap", s_if_valid, 1'b0);
    step();
    chk1("redir_c3_valid", s_if_valid, 1'b1);
    chk("redir_c3_pc", s_if_pc, 32'h40);

    // Unaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    step();
    chk("redir_align", s_imem_addr, 32'h40);
    repeat (4) step();

    // Halt with one fetch in flight
    chk1("pre_halt_issue", s_imem_valid, 1'b1);
    last_addr = s_imem_addr;
    halt = 1'b1;
    repeat (4) step();
    chk1("halt_no_issue", s_imem_valid, 1'b0);
    halt = 1'b0;
    step();
    chk("halt_resume", s_imem_addr, last_addr + 32'd4);
    repeat (3) step();

    // Reset while entries are held and a fetch is outstanding
    if_ready = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    if_ready = 1'b1;
    step();
    chk1("rst_flush", s_if_valid, 1'b0);
    step(); step();
    chk1("rst_c2_valid", s_if_valid, 1'b1);
    chk("rst_c2_pc", s_if_pc, RPC);

    // Random traffic against the stream model
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom_range(0, 1023);
      rst            = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ResetPc, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter Width, default 32, giving the address and instruction width.
REQ-003 The block SHALL have parameter Depth, default 2, giving the output buffer entries (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit, as the single clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, as the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port imem_addr, output, Width bits, carrying the byte address to instruction memory.
REQ-007 The block SHALL have port imem_valid, output, 1 bit, as the read strobe to instruction memory.
REQ-008 The block SHALL have port imem_data, input, Width bits, carrying the instruction word returned one cycle after the strobe and held while the strobe is low.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit, requesting a PC change (branch, jump or trap).
REQ-010 The block SHALL have port redirect_pc, input, Width bits, giving the new fetch byte address.
REQ-011 The block SHALL have port halt, input, 1 bit, which suppresses new fetch issues while high.
REQ-012 The block SHALL have port if_valid, output, 1 bit, set when an instruction is presented to decode.
REQ-013 The block SHALL have port if_ready, input, 1 bit, set when decode accepts the presented instruction.
REQ-014 The block SHALL have port if_pc, output, Width bits, carrying the byte address of the presented instruction.
REQ-015 The block SHALL have port if_instr, output, Width bits, carrying the presented instruction word.

Function
REQ-016 A fetch SHALL issue in cycle N with imem_valid=1 and imem_addr=pc; the word SHALL be captured from imem_data at the end of cycle N+1, so a returned word is accepted into the buffer one cycle after issue.
REQ-017 A fetch SHALL issue only when occupancy + in-flight - pop < Depth and halt=0 and redirect_valid=0 and rst=0, where pop = if_valid & if_ready.
REQ-018 pc SHALL advance by 4 on each issue and wrap modulo 2^Width with no flag.
REQ-019 imem_addr SHALL always have bits [1:0] = 2'b00; redirect_pc[1:0] SHALL be ignored.
REQ-020 The output buffer SHALL be a FIFO of {pc, instr} pairs; if_valid SHALL be 1 iff occupancy > 0, with if_pc and if_instr taken from the head.
REQ-021 A transfer SHALL occur iff if_valid & if_ready; head data SHALL remain stable while if_valid=1 and if_ready=0.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged; a push into an empty buffer SHALL make if_valid=1 in the following cycle (no bypass).
REQ-023 On redirect_valid=1, in that same cycle the block SHALL: flush the buffer (if_valid=0 next cycle), mark any in-flight response as killed, set pc to {redirect_pc[Width-1:2], 2'b00}, and issue nothing.
REQ-024 A killed response SHALL be discarded in its return cycle and never pushed.
REQ-025 A redirect that coincides with a pop SHALL complete the pop (decode consumes the head), then flush.
REQ-026 With no stalls, the first word after a redirect SHALL appear on if_valid 3 cycles after the redirect cycle.
REQ-027 halt SHALL block new issues only; an in-flight fetch SHALL still complete and be buffered, and buffered entries SHALL still drain.
REQ-028 Control SHALL be a two-state machine: RUN (issue permitted) and HALTED (halt=1); RUN->HALTED when halt=1, HALTED->RUN when halt=0; a redirect is honoured in either state.
REQ-029 With if_ready held at 1 and no redirect or halt, throughput SHALL be one instruction per cycle.

Reset
REQ-030 While rst=1: pc=ResetPc, buffer empty, in-flight and kill cleared, state=RUN, imem_valid=0, if_valid=0.
REQ-031 Reset asserted mid-fetch SHALL discard the outstanding response; the first fetch SHALL issue ResetPc in the first cycle after rst falls.
REQ-032 if_pc and if_instr SHALL be don't-care while if_valid=0.

Structure
REQ-033 Width-independent constants (instruction byte size 4, NOP encoding 32'h0000_0013) SHALL live in the shared cpu package.
REQ-034 The {pc, instr} FIFO SHALL be one sub-module, fetch_buffer, parameterised by Depth and entry width, with push, pop, flush, full, empty and count.

Verification
REQ-035 Reset release with if_ready=1 and memory words 0x00000013, 0x00100093 at addresses 0 and 4 -> if_pc=0/if_instr=0x00000013 on cycle 2 after release, if_pc=4 on cycle 3, continuing one per cycle.
REQ-036 if_ready=0 for 5 cycles -> exactly Depth entries buffered, imem_valid=0 once full, head stable; on if_ready=1 -> no entry lost or duplicated.
REQ-037 Redirect to 0x40 issued the cycle after a fetch of 0x10 -> the 0x10 response is dropped and the next if_pc is 0x40, 3 cycles after the redirect.
REQ-038 redirect_pc=0x43 -> imem_addr=0x40.
REQ-039 halt=1 with one fetch in flight -> that word is delivered and no further imem_valid; on halt=0, fetch resumes at pc+4.
REQ-040 rst pulsed while the buffer is full and a fetch is in flight -> if_valid=0 the next cycle, and the next delivered instruction has if_pc=ResetPc.
